// File: rtl/wdog_pkg.sv
// wdog_pkg: shared types and constants for the heartbeat watchdog.
//   wdog_state_e : per-channel FSM state (IDLE, WAIT, REVIVE, DEAD)
//   retry_width  : width of the consecutive-timeout counter for a retry budget
//   DEF_*        : default parameter values used by the watchdog modules
package wdog_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REVIVE = 2'd2,
        DEAD   = 2'd3
    } wdog_state_e;

    localparam int unsigned DEF_NUM_CH    = 4;
    localparam int unsigned DEF_CNT_W     = 32;
    localparam int unsigned DEF_MAX_RETRY = 3;
    localparam int unsigned DEF_PRESCALE  = 50_000;

    // Bits needed to hold 0..max_retry (retry saturates at max_retry).
    function automatic int unsigned retry_width(input int unsigned max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/wdog_channel.sv
// wdog_channel: one heartbeat watchdog channel (FSM, timeout count, retry count).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   tick            count enable (1 every cycle or prescaled pulse)
//   start           monitor enable (level)
//   kick            heartbeat, restarts the timeout and clears retry
//   revive_ack      firmware acknowledge of a revive
//   clear           releases a dead channel
//   timeout_limit   timeout in ticks, 0 treated as 1
//   wait_end        registered 1-cycle pulse when the wait phase ends
//   path_sel        registered, 1 while the channel is on the revive path
//   dead            registered, 1 while the retry budget is exhausted
module wdog_channel
    import wdog_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             kick,
    input  logic             revive_ack,
    input  logic             clear,
    input  logic [CNT_W-1:0] timeout_limit,
    output logic             wait_end,
    output logic             path_sel,
    output logic             dead
);

    localparam int unsigned            RETRY_W   = retry_width(MAX_RETRY);
    localparam logic [RETRY_W:0]       RETRY_MAX = (RETRY_W + 1)'(MAX_RETRY);

    wdog_state_e          state, state_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    logic [RETRY_W-1:0]   retry, retry_nxt;
    logic                 wait_end_nxt, path_sel_nxt, dead_nxt;

    logic [CNT_W-1:0]     limit_m1_c;
    logic [RETRY_W:0]     retry_inc_c;

    // Last count value before expiry; a zero limit behaves like one tick.
    assign limit_m1_c  = (timeout_limit == '0) ? '0 : timeout_limit - CNT_W'(1);
    assign retry_inc_c = {1'b0, retry} + (RETRY_W + 1)'(1);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            retry    <= '0;
            wait_end <= 1'b0;
            path_sel <= 1'b0;
            dead     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            retry    <= retry_nxt;
            wait_end <= wait_end_nxt;
            path_sel <= path_sel_nxt;
            dead     <= dead_nxt;
        end
    end

    // Next-state logic; kick and start-drop act every cycle, counting only on tick.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        retry_nxt    = retry;
        wait_end_nxt = 1'b0;

        case (state)
            IDLE: begin
                count_nxt = '0;
                if (start && !kick) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (kick) begin
                    count_nxt    = '0;
                    retry_nxt    = '0;
                    wait_end_nxt = 1'b1;
                end else if (!start) begin
                    state_nxt    = IDLE;
                    count_nxt    = '0;
                    wait_end_nxt = 1'b1;
                end else if (tick) begin
                    // >= also expires a count stranded above a reduced limit
                    if (count < limit_m1_c) begin
                        count_nxt = count + CNT_W'(1);
                    end else begin
                        count_nxt    = '0;
                        wait_end_nxt = 1'b1;
                        if (retry_inc_c >= RETRY_MAX) begin
                            retry_nxt = RETRY_MAX[RETRY_W-1:0];
                            state_nxt = DEAD;
                        end else begin
                            retry_nxt = retry_inc_c[RETRY_W-1:0];
                            state_nxt = REVIVE;
                        end
                    end
                end
            end
            REVIVE: begin
                if (revive_ack) begin
                    count_nxt = '0;
                    state_nxt = start ? WAIT : IDLE;
                end
            end
            DEAD: begin
                if (clear) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
                retry_nxt = '0;
            end
        endcase

        path_sel_nxt = (state_nxt == REVIVE) || (state_nxt == DEAD);
        dead_nxt     = (state_nxt == DEAD);
    end

endmodule

// File: rtl/heartbeat_watchdog.sv
// heartbeat_watchdog: multi-channel heartbeat watchdog and revive path selector.
// Optional feature macro: WDOG_PRESCALE_EN (shared tick every PRESCALE cycles;
// without it every cycle is a tick).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start[NUM_CH]   per-channel monitor enable
//   kick[NUM_CH]    per-channel heartbeat (priority over start)
//   revive_ack[NUM_CH] firmware acknowledge of a revive
//   clear[NUM_CH]   releases a dead channel
//   timeout_limit   shared timeout in ticks (0 treated as 1)
//   wait_end[NUM_CH] 1-cycle pulse when a wait phase ends
//   path_sel[NUM_CH] 1 = channel on revive path
//   dead[NUM_CH]    channel exhausted its retry budget
//   any_timeout     registered OR of path_sel (one cycle behind)
module heartbeat_watchdog
    import wdog_pkg::*;
#(
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
    parameter int unsigned PRESCALE  = DEF_PRESCALE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] kick,
    input  logic [NUM_CH-1:0] revive_ack,
    input  logic [NUM_CH-1:0] clear,
    input  logic [CNT_W-1:0]  timeout_limit,
    output logic [NUM_CH-1:0] wait_end,
    output logic [NUM_CH-1:0] path_sel,
    output logic [NUM_CH-1:0] dead,
    output logic              any_timeout
);

    // Elaboration-time parameter sanity.
    if (MAX_RETRY < 1) begin : g_bad_retry
        $error("heartbeat_watchdog: MAX_RETRY must be at least 1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("heartbeat_watchdog: PRESCALE must be at least 1");
    end

    logic tick;

`ifdef WDOG_PRESCALE_EN
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt;

    // Free-running prescaler shared by all channels; not restarted by kicks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    assign tick = (ps_cnt == PS_LAST);
`else
    assign tick = 1'b1;
`endif

    // One independent watchdog per channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        wdog_channel #(
            .CNT_W     (CNT_W),
            .MAX_RETRY (MAX_RETRY)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .start         (start[i]),
            .kick          (kick[i]),
            .revive_ack    (revive_ack[i]),
            .clear         (clear[i]),
            .timeout_limit (timeout_limit),
            .wait_end      (wait_end[i]),
            .path_sel      (path_sel[i]),
            .dead          (dead[i])
        );
    end

    // Summary flag, one cycle behind path_sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_timeout <= 1'b0;
        end else begin
            any_timeout <= |path_sel;
        end
    end

endmodule

// File: tb/tb_heartbeat_watchdog.sv
// tb_heartbeat_watchdog: directed table-driven bench for heartbeat_watchdog
// (2 channels, limit 4, MAX_RETRY 3, no prescaler).
module tb_heartbeat_watchdog;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 32;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] kick;
    logic [NUM_CH-1:0] revive_ack;
    logic [NUM_CH-1:0] clear;
    logic [CNT_W-1:0]  timeout_limit;
    logic [NUM_CH-1:0] wait_end;
    logic [NUM_CH-1:0] path_sel;
    logic [NUM_CH-1:0] dead;
    logic              any_timeout;

    heartbeat_watchdog #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .MAX_RETRY (3),
        .PRESCALE  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .kick          (kick),
        .revive_ack    (revive_ack),
        .clear         (clear),
        .timeout_limit (timeout_limit),
        .wait_end      (wait_end),
        .path_sel      (path_sel),
        .dead          (dead),
        .any_timeout   (any_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] kk;
        logic [1:0] ak;
        logic [1:0] cl;
        logic [1:0] we;
        logic [1:0] ps;
        logic [1:0] dd;
        logic       at;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [1:0] st, input logic [1:0] kk, input logic [1:0] ak,
                       input logic [1:0] cl, input logic [1:0] we, input logic [1:0] ps,
                       input logic [1:0] dd, input logic at);
        vec_t v;
        v.st = st; v.kk = kk; v.ak = ak; v.cl = cl;
        v.we = we; v.ps = ps; v.dd = dd; v.at = at;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = '0;
        kick       = '0;
        revive_ack = '0;
        clear      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " wait_end"}, 32'(wait_end), 32'd0);
        chk({nm, " path_sel"}, 32'(path_sel), 32'd0);
        chk({nm, " dead"}, 32'(dead), 32'd0);
        chk({nm, " any_timeout"}, 32'(any_timeout), 32'd0);
    endtask

    initial begin
        int n;
        idle_inputs();
        timeout_limit = 32'd4;
        rst = 1'b1;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        //   start  kick   ack    clear  wait_e path   dead   any
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 0 idle
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 1 -> WAIT
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 2 cnt1
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 3 cnt2
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 4 cnt3
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0); // 5 expiry 1
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1); // 6 revive
        add(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1); // 7 ack -> WAIT
        add(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0); // 8 clear ignored
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 9
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 10
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0); // 11 expiry 2
        add(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1); // 12 ack
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 13
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 14
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 15
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0); // 16 expiry 3 dead
        add(2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1); // 17 ack/kick ignored
        add(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1); // 18 clear -> IDLE
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 19 -> WAIT
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 20 cnt1
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 21 cnt2
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0); // 22 kick
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 23
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 24
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0); // 25 kick
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 26
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 27
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0); // 28 kick
        add(2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0); // 29 kick beats drop
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0); // 30 drop -> IDLE
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0); // 31 idle

        for (int i = 0; i < tv.size(); i++) begin
            start      = tv[i].st;
            kick       = tv[i].kk;
            revive_ack = tv[i].ak;
            clear      = tv[i].cl;
            step();
            chk($sformatf("v%0d wait_end", i), 32'(wait_end), 32'(tv[i].we));
            chk($sformatf("v%0d path_sel", i), 32'(path_sel), 32'(tv[i].ps));
            chk($sformatf("v%0d dead", i), 32'(dead), 32'(tv[i].dd));
            chk($sformatf("v%0d any_timeout", i), 32'(any_timeout), 32'(tv[i].at));
        end

        // REVIVE, drop start, ack -> IDLE; restart gives a fresh full timeout.
        do_reset();
        timeout_limit = 32'd4;
        start = 2'b01;
        repeat (4) step();
        chk("rv pre-expiry path_sel", 32'(path_sel), 32'd0);
        step();
        chk("rv expiry path_sel", 32'(path_sel), 32'd1);
        chk("rv expiry wait_end", 32'(wait_end), 32'd1);
        start = 2'b00;
        step();
        chk("rv start dropped path_sel", 32'(path_sel), 32'd1);
        revive_ack = 2'b01;
        step();
        revive_ack = 2'b00;
        chk("rv ack path_sel", 32'(path_sel), 32'd0);
        step();
        chk("rv idle wait_end", 32'(wait_end), 32'd0);
        start = 2'b01;
        repeat (4) step();
        chk("rv restart pre path_sel", 32'(path_sel), 32'd0);
        step();
        chk("rv restart path_sel", 32'(path_sel), 32'd1);
        chk("rv restart dead", 32'(dead), 32'd0);

        // limit=0 behaves as 1 tick.
        do_reset();
        timeout_limit = 32'd0;
        start = 2'b01;
        step();
        chk("lim0 wait path_sel", 32'(path_sel), 32'd0);
        step();
        chk("lim0 expiry path_sel", 32'(path_sel), 32'd1);
        chk("lim0 expiry wait_end", 32'(wait_end), 32'd1);

        // Limit reduced below current count -> expiry on next tick.
        do_reset();
        timeout_limit = 32'd8;
        start = 2'b01;
        repeat (6) step();
        chk("shrink pre path_sel", 32'(path_sel), 32'd0);
        timeout_limit = 32'd2;
        step();
        chk("shrink expiry path_sel", 32'(path_sel), 32'd1);

        // Drive ch0 to DEAD, ch1 into WAIT, then reset mid-operation.
        do_reset();
        timeout_limit = 32'd4;
        start = 2'b01;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!path_sel[0] && n < 20);
            chk($sformatf("dead seq expiry %0d", k), 32'(path_sel[0]), 32'd1);
            if (k < 2) begin
                revive_ack = 2'b01;
                step();
                revive_ack = 2'b00;
            end
        end
        chk("dead seq dead", 32'(dead), 32'd1);
        start = 2'b10;
        step();
        step();
        chk("dead seq ch1 waiting", 32'(path_sel), 32'd1);
        chk("dead seq any_timeout", 32'(any_timeout), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async rst");
        @(posedge clk);
        #1;
        chk_all_zero("rst held");
        rst = 1'b0;
        repeat (4) step();
        chk("post rst ch1 pre path_sel", 32'(path_sel), 32'd0);
        step();
        chk("post rst ch1 path_sel", 32'(path_sel), 32'd2);
        chk("post rst ch1 wait_end", 32'(wait_end), 32'd2);
        chk("post rst dead", 32'(dead), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/heartbeat_watchdog.md
# heartbeat_watchdog

Multi-channel heartbeat watchdog and path selector. Each channel runs a timeout counter while its start request is high, restarts it on every heartbeat kick, and on expiry switches its channel to the revive path until firmware acknowledges. Consecutive timeouts are counted; a channel that exceeds its retry budget latches dead. It sits between the controller heartbeat sources and the revive/recovery logic, one channel per monitored agent.

## Interface
- NUM_CH, 4, number of independent channels
- CNT_W, 32, width of timeout counter and timeout_limit
- MAX_RETRY, 3, consecutive timeouts that mark a channel dead (≥1)
- PRESCALE, 50_000, cycles per tick when the prescaler is compiled in
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  NUM_CH  per-channel monitor enable (level)
- kick  input  NUM_CH  per-channel heartbeat; priority over start
- revive_ack  input  NUM_CH  firmware acknowledge of a revive (1-cycle pulse)
- clear  input  NUM_CH  releases a dead channel
- timeout_limit  input  CNT_W  shared timeout in ticks, quasi-static; 0 treated as 1
- wait_end  output  NUM_CH  1-cycle pulse: wait phase ended (timeout, kick, or drop to idle)
- path_sel  output  NUM_CH  1 = channel on revive path
- dead  output  NUM_CH  channel exhausted its retry budget
- any_timeout  output  1  registered OR of path_sel

## Operation
- Per-channel states: IDLE, WAIT, REVIVE, DEAD. Per-channel count (CNT_W) and retry (clog2(MAX_RETRY+1) bits).
- IDLE: count=0. start=1 and kick=0 → WAIT with count=0.
- WAIT, per tick, priority order:
  - kick=1 → count=0, retry=0, wait_end pulse, stay WAIT.
  - start=0 → IDLE, count=0, wait_end pulse; retry kept.
  - count < limit-1 → count+1.
  - else (expiry) → count=0, wait_end pulse, retry+1; if retry+1 == MAX_RETRY → DEAD, else REVIVE.
- Kick and start=0 are evaluated every cycle, not only on ticks; only increment and expiry wait for a tick.
- REVIVE: path_sel=1; start and kick ignored. revive_ack → WAIT (count=0) if start=1, else IDLE. Retry held.
- DEAD: path_sel=1, dead=1; only clear exits → IDLE, retry=0. ack and kick ignored.
- clear in any other state: no effect.
- Channels are fully independent; simultaneous events on different channels do not interact.
- retry saturates at MAX_RETRY; count never exceeds limit-1. If limit drops below current count, the next tick expires.

## Timing
- Reset: all channels IDLE, count=0, retry=0; wait_end=0, path_sel=0, dead=0, any_timeout=0.
- All outputs registered; any_timeout lags path_sel by one cycle.
- Without the prescaler (tick every cycle), start rising at edge E sets WAIT at E+1, and path_sel rises at edge E+1+L for limit L. wait_end pulses in the same cycle.
- revive_ack sampled at edge A: path_sel is 0 after A.
- Reset mid-operation: immediate return to the reset values, including DEAD channels.

## Configuration
- WDOG_PRESCALE_EN defined: a free-running prescaler produces a 1-cycle tick every PRESCALE cycles, shared by all channels, so timeout_limit is in ticks. The prescaler resets to 0 on rst. It does not restart on kick, so expiry jitter is up to one tick.
- Undefined: tick is constant 1 and timeout_limit is in clk cycles. No prescaler logic is instantiated.

## Structure
- Package wdog_pkg: state enum (IDLE, WAIT, REVIVE, DEAD) and the retry-width function/constant.
- Sub-module wdog_channel: one channel's FSM, count and retry, with tick as an input. The top holds the prescaler, generates NUM_CH instances, and registers any_timeout.

## Test plan
- NUM_CH=2, limit=4, no prescale; start[0]=1 held, no kick → path_sel[0] rises 5 cycles after start with a wait_end[0] pulse; ch1 stays 0.
- Same setup, kick[0] every 3 cycles → path_sel[0] never rises; wait_end[0] pulses on each kick.
- MAX_RETRY=3, repeated timeout+ack → 3rd expiry sets dead[0]=1 and path_sel[0]=1; ack ignored; clear[0] → IDLE, dead=0.
- In REVIVE, drop start then ack → IDLE, path_sel=0; reassert start → new timeout after 4+1 cycles.
- In WAIT, kick and start=0 on the same cycle → kick wins, stays WAIT, count=0. limit=0 → expiry after 1 tick.
- Assert rst while ch0 is DEAD and ch1 in WAIT → all outputs 0 immediately; ch1 restarts a full timeout after rst releases.
